uart_tx_fifo_drain: RTL
=======================

Name: uart_tx_fifo_drain

Overview:
UART transmitter that sits directly downstream of the core's byte FIFO and drains it onto a serial TX line. It pops one word whenever it is idle and the FIFO is not empty. It serialises the word as start bit, data bits LSB first, then stop bit, at a fixed baud set by a clock-divider parameter. It uses the FIFO's show-ahead interface: read data is valid combinationally whenever empty is low, and a one-cycle read strobe advances the FIFO.

Parameters:
DATA_BITS, 8, width of each FIFO word and number of data bits per frame (1..16)
CLKS_PER_BIT, 868, i_clk cycles per serial bit (100 MHz / 115200); must be >= 2; baud counter width $clog2(CLKS_PER_BIT)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_fifo_data  input  DATA_BITS  FIFO head word, valid while i_fifo_empty is low
i_fifo_empty  input  1  FIFO empty flag
o_fifo_rd_en  output  1  one-cycle pop strobe to FIFO read enable
o_tx  output  1  serial line, idle high, registered
o_busy  output  1  high whenever a frame is in progress (state != IDLE), registered
o_done  output  1  one-cycle pulse on the last cycle of the stop bit, registered

Behaviour:
- Reset is synchronous, active-high, on i_clk (i_rst). It forces: state=IDLE, o_tx=1, o_busy=0, o_done=0, bit counter=0, baud counter=0, shift register=0.
- o_fifo_rd_en is combinational: (state==IDLE) && !i_fifo_empty && !i_rst. It is never asserted outside IDLE, so at most one pop per frame and no double pop.
- IDLE:
  - If !i_fifo_empty at edge T: latch i_fifo_data into the shift register, assert o_fifo_rd_en during cycle T, go to START.
  - Otherwise hold, with o_tx=1.
- START:
  - o_tx=0 for exactly CLKS_PER_BIT cycles, starting at cycle T+1.
  - Baud counter counts 0..CLKS_PER_BIT-1; on terminal count, reset it and go to DATA.
- DATA:
  - o_tx = shift[0]; on each terminal count, shift right by 1 and increment the bit counter.
  - After DATA_BITS bits, go to STOP (or PARITY, see Optional Feature).
- STOP:
  - o_tx=1 for CLKS_PER_BIT cycles.
  - o_done=1 on the final cycle; then return to IDLE.
- Frame timing:
  - Frame occupies cycles T+1 .. T+(DATA_BITS+2)*CLKS_PER_BIT.
  - The block spends at least one cycle in IDLE between frames.
  - Back-to-back pop spacing = (DATA_BITS+2)*CLKS_PER_BIT + 1 cycles.
- Stability: o_tx changes only at bit boundaries; no glitches, because it is registered.
- i_fifo_data and i_fifo_empty are ignored outside IDLE. A FIFO write mid-frame does not affect the frame in flight.
- Reset mid-frame:
  - Frame is aborted; o_tx=1 and o_busy=0 on the cycle after the reset edge.
  - The already-popped word is discarded, never retransmitted.
  - After reset deasserts, a non-empty FIFO pops on the first IDLE cycle.
- If i_rst and !i_fifo_empty occur in the same cycle: no pop (reset wins).
- Counter wrap: the baud counter never exceeds CLKS_PER_BIT-1; the bit counter never exceeds DATA_BITS-1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - o_tx = XOR of the latched data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
  - Pop spacing becomes (DATA_BITS+3)*CLKS_PER_BIT + 1.
- When undefined: no PARITY state, no parity logic; frame as described in Behaviour.

Test Plan:
- Reset: i_rst=1 for 5 cycles with i_fifo_empty=0 -> o_fifo_rd_en=0, o_tx=1, o_busy=0, o_done=0 throughout.
- Single word (CLKS_PER_BIT=4, DATA_BITS=8): i_fifo_data=0xA5, empty low at T.
  - o_fifo_rd_en=1 only at T.
  - o_tx in 4-cycle bits from T+1 = 0,1,0,1,0,0,1,0,1,1.
  - o_done=1 at T+40; o_busy falls at T+41.
- Back-to-back (CLKS_PER_BIT=4): FIFO holds 0x00 then 0xFF -> pops at T and T+41; second frame data bits all 1; exactly one idle-high cycle between frames.
- Idle: i_fifo_empty=1 for 100 cycles -> o_fifo_rd_en never asserted, o_tx=1, o_busy=0.
- Reset mid-frame: assert i_rst during data bit 3 of 0x3C, deassert with empty=0 -> o_tx=1 and o_busy=0 the next cycle; new pop on first post-reset cycle; new frame starts with a full 4-cycle start bit.
- UART_TX_PARITY_EN defined (CLKS_PER_BIT=4): 0x07 -> parity bit 1 for 4 cycles after bit 7, stop follows, o_done at T+44, next pop at T+45; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead byte FIFO: start bit, LSB-first data, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_drain #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(32'd0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(32'd1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(32'd0);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(32'd1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
        return ^word;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t                 state_r;
    state_t                 state_s;
    logic [BAUD_W-1:0]      baud_r;
    logic [BAUD_W-1:0]      baud_s;
    logic [BIT_W-1:0]       bit_r;
    logic [BIT_W-1:0]       bit_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   shift_s;
    logic                   tx_r;
    logic                   tx_s;
    logic                   busy_r;
    logic                   busy_s;
    logic                   done_r;
    logic                   done_s;
    logic                   pop_s;
`ifdef UART_TX_PARITY_EN
    logic                   parity_r;
    logic                   parity_s;
`endif

    // Reset wins over a pending pop so a word is never lost into a reset.
    assign pop_s        = (state_r == S_IDLE) && !i_fifo_empty && !i_rst;
    assign o_fifo_rd_en = pop_s;
    assign o_tx         = tx_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;

    // Next-state logic: frame sequencing, baud and bit counting, shift register.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (pop_s) begin
                    shift_s = i_fifo_data;
                    baud_s  = BAUD_ZERO;
                    bit_s   = BIT_ZERO;
                    state_s = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_s = even_parity(i_fifo_data);
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    state_s = S_DATA;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = shift_r >> 1'b1;
                    if (bit_r == BIT_LAST) begin
                        bit_s = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    state_s = S_STOP;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    state_s = S_IDLE;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                baud_s  = BAUD_ZERO;
                bit_s   = BIT_ZERO;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered line lines up with the state.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_STOP) && (baud_s == BAUD_LAST);
        case (state_s)
            S_IDLE:   tx_s = 1'b1;
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_s = parity_s;
`endif
            S_STOP:   tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

endmodule
